// File: rtl/oled_spi_pkg.sv
// Shared definitions for the SSD1331 SPI path: serializer states, pin idle levels and the
// default transfer width also used by the upstream MOSI byte buffer.
package oled_spi_pkg;

  localparam int unsigned SpiWidth = 8;
  localparam logic        SclkIdle = 1'b0;
  localparam bit          MsbFirst = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_mosi_tx_if.sv
// Byte/D-C/start stream from the upstream MOSI buffer plus the OLED pins driven by the serializer.
interface spi_mosi_tx_if #(
  parameter int unsigned WIDTH = oled_spi_pkg::SpiWidth
);
  logic [WIDTH-1:0] i_DATA;
  logic             i_DC;
  logic             i_START;
  logic             o_SCLK;
  logic             o_MOSI;
  logic             o_CS_N;
  logic             o_DC;
  logic             o_MOSI_FINAL_BIT;
  logic             o_BUSY;

  modport master (
    output i_DATA, i_DC, i_START,
    input  o_SCLK, o_MOSI, o_CS_N, o_DC, o_MOSI_FINAL_BIT, o_BUSY
  );

  modport slave (
    input  i_DATA, i_DC, i_START,
    output o_SCLK, o_MOSI, o_CS_N, o_DC, o_MOSI_FINAL_BIT, o_BUSY
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK phase generator: runs 0..2*HALF_DIV-1 while enabled, parks at phase 0 with SCLK idle.
module spi_sclk_gen
  import oled_spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic i_SCK,
  input  logic i_RST_N,
  input  logic i_EN,
  output logic o_SCLK,
  output logic o_PHASE0,
  output logic o_LAST_PHASE
);
  localparam int unsigned       PhaseW    = (2 * HALF_DIV > 1) ? $clog2(2 * HALF_DIV) : 1;
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(2 * HALF_DIV - 1);
  localparam logic [PhaseW-1:0] HighPhase = PhaseW'(HALF_DIV);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              sclk_q, sclk_d;

  // SCLK is derived from the next phase so the pin itself is a flop.
  always_comb begin
    phase_d = '0;
    sclk_d  = SclkIdle;
    if (i_EN) begin
      phase_d = (phase_q == LastPhase) ? '0 : phase_q + PhaseW'(1);
      sclk_d  = (phase_d >= HighPhase) ? ~SclkIdle : SclkIdle;
    end
  end

  always_ff @(posedge i_SCK) begin
    if (!i_RST_N) begin
      phase_q <= '0;
      sclk_q  <= SclkIdle;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign o_SCLK       = sclk_q;
  assign o_PHASE0     = i_EN && (phase_q == '0);
  assign o_LAST_PHASE = i_EN && (phase_q == LastPhase);

endmodule

// File: rtl/spi_mosi_tx.sv
// SSD1331 MOSI serializer: shifts bytes out MSB first in SPI mode 0, keeps CS# low across
// back-to-back bytes and frames each burst with CS# setup/hold time.
module spi_mosi_tx
  import oled_spi_pkg::*;
#(
  parameter int unsigned WIDTH    = SpiWidth,
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1
) (
  input logic          i_SCK,
  input logic          i_RST_N,
  spi_mosi_tx_if.slave bus
);
  localparam int unsigned     CntMax    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned     CntW      = $clog2(CntMax + 1);
  localparam int unsigned     IdxW      = $clog2(WIDTH);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [IdxW-1:0] IdxTop    = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] IdxOne    = IdxW'(1);

  spi_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [IdxW-1:0]  bit_idx_q;
  logic [CntW-1:0]  cnt_q;
  logic             mosi_q, cs_n_q, dc_q, final_bit_q, busy_q;
  logic             sclk, sclk_phase0, sclk_last;

  function automatic logic lead_bit(input logic [WIDTH-1:0] d);
    return MsbFirst ? d[WIDTH-1] : d[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return MsbFirst ? (d << 1) : (d >> 1);
  endfunction

  spi_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk_gen (
    .i_SCK       (i_SCK),
    .i_RST_N     (i_RST_N),
    .i_EN        (state_q == StShift),
    .o_SCLK      (sclk),
    .o_PHASE0    (sclk_phase0),
    .o_LAST_PHASE(sclk_last)
  );

  always_ff @(posedge i_SCK) begin
    if (!i_RST_N) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      dc_q        <= 1'b0;
      final_bit_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      final_bit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_START) begin
            shift_q <= bus.i_DATA;
            dc_q    <= bus.i_DC;
            mosi_q  <= lead_bit(bus.i_DATA);
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q     <= '0;
            bit_idx_q <= IdxTop;
            state_q   <= StShift;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StShift: begin
          if (sclk_last) begin
            if (bit_idx_q != '0) begin
              bit_idx_q   <= bit_idx_q - IdxW'(1);
              shift_q     <= advance(shift_q);
              mosi_q      <= lead_bit(advance(shift_q));
              final_bit_q <= (bit_idx_q == IdxOne);
            end else if (bus.i_START) begin
              // Chain the next byte with no SCLK gap; CS# stays low.
              shift_q   <= bus.i_DATA;
              dc_q      <= bus.i_DC;
              mosi_q    <= lead_bit(bus.i_DATA);
              bit_idx_q <= IdxTop;
            end else begin
              cnt_q   <= '0;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The final-bit pulse is registered one edge early; it must land on the first phase of bit 0.
  always_comb begin
    if (i_RST_N && final_bit_q) begin
      assert (sclk_phase0);
    end
  end

  assign bus.o_SCLK           = sclk;
  assign bus.o_MOSI           = mosi_q;
  assign bus.o_CS_N           = cs_n_q;
  assign bus.o_DC             = dc_q;
  assign bus.o_MOSI_FINAL_BIT = final_bit_q;
  assign bus.o_BUSY           = busy_q;

endmodule

// File: tb/tb_spi_mosi_tx.sv
// Bench for spi_mosi_tx under two parameter sets: an upstream-buffer model issues random bursts,
// an OLED-side decoder rebuilds bytes on SCLK rises and checks them and the frame timing.
module tb_spi_mosi_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic tally(input int cfg, input bit ok, input string name, input int act,
                       input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cfg%0d %s: got 0x%0h, required 0x%0h", cfg, name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int HD = (g == 0) ? 2 : 1;
    localparam int SU = (g == 0) ? 1 : 3;
    localparam int HO = (g == 0) ? 1 : 2;

    logic       rst_n = 1'b0;
    logic       rst_seen;
    int         cyc      = 0;
    int         rx_bytes = 0;
    int         fb_count = 0;
    bit         done     = 1'b0;
    logic [8:0] exp_q[$];

    spi_mosi_tx_if #(.WIDTH(8)) bus ();

    spi_mosi_tx #(
      .WIDTH   (8),
      .HALF_DIV(HD),
      .CS_SETUP(SU),
      .CS_HOLD (HO)
    ) u_dut (
      .i_SCK  (clk),
      .i_RST_N(rst_n),
      .bus    (bus)
    );

    always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst_n;
    end

    // OLED-side decoder: samples MOSI on SCLK rising, pops the scoreboard per decoded byte.
    initial begin : mon
      logic       prev_sclk, prev_cs, prev_fb, dc0, rise_pending;
      int         cs_fall, last_rise, nbits;
      logic [7:0] acc;
      logic [8:0] req_v;
      prev_sclk = 1'b0; prev_cs = 1'b1; prev_fb = 1'b0; dc0 = 1'b0; rise_pending = 1'b0;
      cs_fall = 0; last_rise = 0; nbits = 0; acc = '0;
      forever begin
        @(negedge clk);
        if (rst_seen !== 1'b1) begin
          prev_sclk = 1'b0; prev_cs = 1'b1; prev_fb = 1'b0; nbits = 0; rise_pending = 1'b0;
          continue;
        end
        if (prev_cs && !bus.o_CS_N) begin
          cs_fall      = cyc;
          rise_pending = 1'b1;
          tally(g, bus.o_BUSY == 1'b1, "busy_at_cs_fall", int'(bus.o_BUSY), 1);
        end
        if (!prev_cs && bus.o_CS_N) begin
          tally(g, cyc - last_rise == HD + HO, "last_rise_to_cs_high", cyc - last_rise, HD + HO);
          tally(g, nbits == 0, "partial_byte_at_cs_high", nbits, 0);
          tally(g, bus.o_BUSY == 1'b0, "busy_after_hold", int'(bus.o_BUSY), 0);
          tally(g, bus.o_MOSI == 1'b0, "mosi_idle", int'(bus.o_MOSI), 0);
        end
        if (!prev_sclk && bus.o_SCLK) begin
          tally(g, bus.o_CS_N == 1'b0, "cs_low_at_rise", int'(bus.o_CS_N), 0);
          if (rise_pending) begin
            tally(g, cyc - cs_fall == SU + HD, "cs_fall_to_first_rise", cyc - cs_fall, SU + HD);
            rise_pending = 1'b0;
          end else begin
            tally(g, cyc - last_rise == 2 * HD, "rise_spacing", cyc - last_rise, 2 * HD);
          end
          last_rise = cyc;
          if (nbits == 0) dc0 = bus.o_DC;
          else tally(g, bus.o_DC == dc0, "dc_stable", int'(bus.o_DC), int'(dc0));
          acc = {acc[6:0], bus.o_MOSI};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            rx_bytes++;
            if (exp_q.size() == 0) begin
              tally(g, 1'b0, "unexpected_byte", int'({dc0, acc}), 0);
            end else begin
              req_v = exp_q.pop_front();
              tally(g, {dc0, acc} == req_v, "byte_dc_data", int'({dc0, acc}), int'(req_v));
            end
          end
        end
        if (bus.o_MOSI_FINAL_BIT) begin
          tally(g, !prev_fb, "final_bit_single_cycle", int'(prev_fb), 0);
          tally(g, nbits == 7, "final_bit_position", nbits, 7);
          fb_count++;
        end
        prev_sclk = bus.o_SCLK;
        prev_cs   = bus.o_CS_N;
        prev_fb   = bus.o_MOSI_FINAL_BIT;
      end
    end

    // Upstream buffer model: level start, next byte staged on the final-bit pulse.
    initial begin : drv
      logic [7:0] bd[4];
      logic       bdc[4];
      int         n, lim, rises;
      logic       prev;
      bit         poke;
      bus.i_START = 1'b0;
      bus.i_DATA  = '0;
      bus.i_DC    = 1'b0;
      repeat (3) @(negedge clk);
      tally(g, bus.o_CS_N == 1'b1, "reset_cs_n", int'(bus.o_CS_N), 1);
      tally(g, bus.o_SCLK == 1'b0, "reset_sclk", int'(bus.o_SCLK), 0);
      tally(g, bus.o_MOSI == 1'b0, "reset_mosi", int'(bus.o_MOSI), 0);
      tally(g, bus.o_DC == 1'b0, "reset_dc", int'(bus.o_DC), 0);
      tally(g, bus.o_MOSI_FINAL_BIT == 1'b0, "reset_final", int'(bus.o_MOSI_FINAL_BIT), 0);
      tally(g, bus.o_BUSY == 1'b0, "reset_busy", int'(bus.o_BUSY), 0);
      rst_n = 1'b1;
      for (int b = 0; b < 14; b++) begin
        poke = 1'($urandom_range(0, 1));
        if (b == 0) begin
          n = 1; bd[0] = 8'hA5; bdc[0] = 1'b0;
        end else if (b == 1) begin
          n = 2; bd[0] = 8'h81; bdc[0] = 1'b0; bd[1] = 8'h3C; bdc[1] = 1'b1;
        end else if (b == 2) begin
          n = 3; bd[0] = 8'h11; bdc[0] = 1'b0; bd[1] = 8'h22; bdc[1] = 1'b1;
          bd[2] = 8'h33; bdc[2] = 1'b1;
        end else if (b == 7) begin
          n = 1; bd[0] = 8'h0F; bdc[0] = 1'($urandom);
        end else begin
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < 4; k++) begin
            bd[k]  = 8'($urandom);
            bdc[k] = 1'($urandom);
          end
        end
        if (b == 7) begin
          // Abort an 8'hFF byte after its fourth SCLK rise; nothing of it may be decoded.
          lim = 0;
          while (bus.o_BUSY !== 1'b0 && lim < 200) begin @(negedge clk); lim++; end
          bus.i_START = 1'b1; bus.i_DATA = 8'hFF; bus.i_DC = 1'($urandom);
          @(negedge clk);
          bus.i_START = 1'b0;
          rises = 0; lim = 0; prev = bus.o_SCLK;
          while (rises < 4 && lim < 200) begin
            @(negedge clk);
            if (bus.o_SCLK && !prev) rises++;
            prev = bus.o_SCLK;
            lim++;
          end
          tally(g, rises == 4, "midbyte_rises", rises, 4);
          rst_n = 1'b0;
          @(negedge clk);
          tally(g, bus.o_CS_N == 1'b1, "midrst_cs_n", int'(bus.o_CS_N), 1);
          tally(g, bus.o_SCLK == 1'b0, "midrst_sclk", int'(bus.o_SCLK), 0);
          tally(g, bus.o_MOSI == 1'b0, "midrst_mosi", int'(bus.o_MOSI), 0);
          tally(g, bus.o_DC == 1'b0, "midrst_dc", int'(bus.o_DC), 0);
          tally(g, bus.o_MOSI_FINAL_BIT == 1'b0, "midrst_final", int'(bus.o_MOSI_FINAL_BIT), 0);
          tally(g, bus.o_BUSY == 1'b0, "midrst_busy", int'(bus.o_BUSY), 0);
          rst_n = 1'b1;
        end
        for (int k = 0; k < n; k++) exp_q.push_back({bdc[k], bd[k]});
        lim = 0;
        while (bus.o_BUSY !== 1'b0 && lim < 200) begin @(negedge clk); lim++; end
        if (lim >= 200) tally(g, 1'b0, "idle_timeout", int'(bus.o_BUSY), 0);
        bus.i_START = 1'b1; bus.i_DATA = bd[0]; bus.i_DC = bdc[0];
        @(negedge clk);
        if (n == 1) begin
          // Start still high during setup must not queue a second byte.
          @(negedge clk);
          bus.i_START = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
          lim = 0;
          do begin
            @(negedge clk);
            lim++;
          end while (bus.o_MOSI_FINAL_BIT !== 1'b1 && lim < 200);
          if (bus.o_MOSI_FINAL_BIT !== 1'b1) tally(g, 1'b0, "final_bit_timeout", 0, 1);
          if (k < n - 1) begin
            bus.i_DATA = bd[k+1];
            bus.i_DC   = bdc[k+1];
          end else begin
            bus.i_START = 1'b0;
            bus.i_DATA  = 8'($urandom);
          end
        end
        if (poke) begin
          // One-cycle start pulse in the first hold cycle must be ignored.
          repeat (2 * HD) @(negedge clk);
          bus.i_START = 1'b1;
          @(negedge clk);
          bus.i_START = 1'b0;
        end
      end
      lim = 0;
      while (bus.o_BUSY !== 1'b0 && lim < 200) begin @(negedge clk); lim++; end
      repeat (4) @(negedge clk);
      tally(g, exp_q.size() == 0, "bytes_outstanding", exp_q.size(), 0);
      tally(g, fb_count == rx_bytes, "final_bit_count", fb_count, rx_bytes);
      done = 1'b1;
    end
  end

  initial begin : ctl
    int lim;
    lim = 0;
    while (!(g_cfg[0].done && g_cfg[1].done) && lim < 60000) begin
      @(posedge clk);
      lim++;
    end
    if (lim >= 60000) tally(-1, 1'b0, "run_timeout", lim, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
